// File: rtl/ns_arb_pkg.sv
// Shared types and helpers for the ns_* arbiter family.
// Holds the FSM state enum, the default weight width and the find-first-one helper.
package ns_arb_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_st_e;

   localparam int DFLT_WGT_W = 4;
   localparam int ARB_MAX    = 64;

   // Lowest set bit of a double-width (unrolled circular) request vector, -1 if none.
   // Masking the low copy below the pointer turns this into a circular search from ptr.
   function automatic int dbl_ff1_idx(input logic [2*ARB_MAX-1:0] vec);
      dbl_ff1_idx = -1;
      for (int i = 2*ARB_MAX-1; i >= 0; i--) begin
         if (vec[i]) dbl_ff1_idx = i;
      end
   endfunction

endpackage

// File: rtl/ns_rr_pick.sv
// Combinational circular priority picker: first set bit of vec at or above ptr, wrapping.
// Built as a double-width masked find-first so it drops into any round-robin arbiter.
module ns_rr_pick
   import ns_arb_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [2*N-1:0] dbl_m;
   int             pos;
   int             p;

   always_comb begin
      dbl_m  = {vec, vec} & ~(((2*N)'(1) << ptr) - (2*N)'(1));
      pos    = dbl_ff1_idx((2*ARB_MAX)'(dbl_m));
      found  = (pos >= 0);
      p      = 0;
      onehot = '0;
      idx    = '0;
      if (found) begin
         p         = (pos >= N) ? pos - N : pos;
         onehot[p] = 1'b1;
         idx       = IW'(p);
      end
   end

endmodule

// File: rtl/ns_gnrl_wrr_lock_arb.sv
// Weighted round-robin arbiter with per-channel credit, lock hold and request mask.
// Grant outputs are registered; release re-arbitrates in the same edge without a bubble.
module ns_gnrl_wrr_lock_arb
   import ns_arb_pkg::*;
#(
   parameter int ARBT_NUM = 8,
   parameter int WGT_W    = DFLT_WGT_W,
   parameter int IDX_W    = $clog2(ARBT_NUM)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ARBT_NUM-1:0]       req_vec,
   input  logic [ARBT_NUM-1:0]       req_mask_vec,
   input  logic [ARBT_NUM*WGT_W-1:0] wgt_vec,
   input  logic                      arbt_ena,
   input  logic                      lock,
   output logic [ARBT_NUM-1:0]       grt_vec,
   output logic [IDX_W-1:0]          grt_idx,
   output logic                      grt_vld
);

   arb_st_e             st_q, st_n;
   logic [IDX_W-1:0]    ptr_q, ptr_n, nxt_ptr, pick_ptr, pick_idx, grt_idx_n;
   logic [WGT_W-1:0]    cred_q, cred_n, pick_wgt;
   logic [ARBT_NUM-1:0] elig, pick_oh, grt_vec_n;
   logic                pick_found, grt_vld_n, rel, ld;

   assign elig     = req_vec & ~req_mask_vec;
   assign nxt_ptr  = (grt_idx == IDX_W'(ARBT_NUM-1)) ? '0 : grt_idx + IDX_W'(1);
   // On release the search starts just past the old grant, so it wins only when alone.
   assign pick_ptr = (st_q == ARB_GRANT) ? nxt_ptr : ptr_q;
   assign pick_wgt = wgt_vec[int'(pick_idx)*WGT_W +: WGT_W];

   ns_rr_pick #(.N(ARBT_NUM), .IW(IDX_W)) u_pick (
      .vec    (elig),
      .ptr    (pick_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      st_n      = st_q;
      ptr_n     = ptr_q;
      cred_n    = cred_q;
      grt_vec_n = grt_vec;
      grt_idx_n = grt_idx;
      grt_vld_n = grt_vld;
      rel       = 1'b0;
      ld        = 1'b0;
      if (arbt_ena) begin
         case (st_q)
            ARB_IDLE: ld = pick_found;
            ARB_GRANT: begin
               if (!elig[grt_idx]) begin
                  rel = 1'b1;
               end else if (!lock) begin
                  if (cred_q != '0) cred_n = cred_q - WGT_W'(1);
                  else              rel    = 1'b1;
               end
            end
            default: ;
         endcase
         if (rel) begin
            ptr_n = nxt_ptr;
            ld    = pick_found;
            if (!pick_found) begin
               st_n      = ARB_IDLE;
               grt_vec_n = '0;
               grt_vld_n = 1'b0;
            end
         end
         if (ld) begin
            st_n      = ARB_GRANT;
            grt_vec_n = pick_oh;
            grt_idx_n = pick_idx;
            grt_vld_n = 1'b1;
            cred_n    = (pick_wgt == '0) ? '0 : pick_wgt - WGT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= ARB_IDLE;
         ptr_q   <= '0;
         cred_q  <= '0;
         grt_vec <= '0;
         grt_idx <= '0;
         grt_vld <= 1'b0;
      end else begin
         st_q    <= st_n;
         ptr_q   <= ptr_n;
         cred_q  <= cred_n;
         grt_vec <= grt_vec_n;
         grt_idx <= grt_idx_n;
         grt_vld <= grt_vld_n;
      end
   end

endmodule

// File: tb/tb_ns_gnrl_wrr_lock_arb.sv
// Directed bench for ns_gnrl_wrr_lock_arb with a behavioural grant model checked every cycle.
// Hand-computed grant sequences pin the model for each scenario.
module tb_ns_gnrl_wrr_lock_arb;

   localparam int N  = 8;
   localparam int W  = 4;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_vec = '0;
   logic [N-1:0]    req_mask_vec = '0;
   logic [N*W-1:0]  wgt_vec = '0;
   logic            arbt_ena = 1'b1;
   logic            lock = 1'b0;
   logic [N-1:0]    grt_vec;
   logic [IW-1:0]   grt_idx;
   logic            grt_vld;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   always #5 clk = ~clk;

   ns_gnrl_wrr_lock_arb #(.ARBT_NUM(N), .WGT_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_vec      (req_vec),
      .req_mask_vec (req_mask_vec),
      .wgt_vec      (wgt_vec),
      .arbt_ena     (arbt_ena),
      .lock         (lock),
      .grt_vec      (grt_vec),
      .grt_idx      (grt_idx),
      .grt_vld      (grt_vld)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who holds the grant, remaining credit, and where the next search starts.
   int           m_vld = 0, m_idx = 0, m_ptr = 0, m_cred = 0;
   int           m_c, m_w;
   bit           m_rel;
   logic [N-1:0] m_e;

   function automatic int m_pick(input logic [N-1:0] e, input int p);
      m_pick = -1;
      for (int k = N-1; k >= 0; k--) begin
         if (e[(p + k) % N]) m_pick = (p + k) % N;
      end
   endfunction

   task automatic m_grant(input int p);
      m_c = m_pick(m_e, p);
      if (m_c >= 0) begin
         m_vld  = 1;
         m_idx  = m_c;
         m_w    = int'(wgt_vec[m_c*W +: W]);
         m_cred = ((m_w == 0) ? 1 : m_w) - 1;
      end else begin
         m_vld = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld = 0; m_idx = 0; m_ptr = 0; m_cred = 0;
      end else if (arbt_ena) begin
         m_e   = req_vec & ~req_mask_vec;
         m_rel = 1'b0;
         if (m_vld == 0) begin
            m_grant(m_ptr);
         end else begin
            if (!m_e[m_idx])     m_rel = 1'b1;
            else if (lock)       m_rel = 1'b0;
            else if (m_cred > 0) m_cred = m_cred - 1;
            else                 m_rel = 1'b1;
            if (m_rel) begin
               m_ptr = (m_idx + 1) % N;
               m_grant(m_ptr);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         chk("model_vec", 32'(grt_vec), (m_vld != 0) ? (32'd1 << m_idx) : 32'd0);
         chk("model_idx", 32'(grt_idx), 32'(m_idx));
         chk("model_vld", 32'(grt_vld), 32'(m_vld));
         chk("onehot0",   32'($onehot0(grt_vec)), 32'd1);
         chk("vld_or",    32'(grt_vld), 32'(|grt_vec));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_vec", 32'(grt_vec), 32'h0);
      chk("rst_idx", 32'(grt_idx), 32'h0);
      chk("rst_vld", 32'(grt_vld), 32'h0);
      rst    = 1'b0;
      chk_on = 1'b1;

      // Fair alternation with 7->0 wrap
      wgt_vec = 32'h1111_1111;
      req_vec = 8'h81;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("fair", 32'(grt_vec), (k % 2 == 1) ? 32'h80 : 32'h01);
      end
      req_vec = 8'h00;
      tick();
      chk("fair_idle_vld", 32'(grt_vld), 32'h0);
      chk("fair_idle_idx", 32'(grt_idx), 32'h7);

      // Weighting: ch0=3, ch1=1
      wgt_vec = 32'h0000_0013;
      req_vec = 8'h03;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("wgt", 32'(grt_vec), (k % 4 == 3) ? 32'h02 : 32'h01);
      end
      req_vec = 8'h00;
      tick();
      chk("wgt_idle", 32'(grt_vec), 32'h0);

      // Weight 0 on ch2 gives one grant per turn, re-won while alone
      wgt_vec = 32'h0;
      req_vec = 8'h04;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wgt0", 32'(grt_vec), 32'h04);
      end
      req_vec = 8'h00;
      tick();
      chk("wgt0_idle", 32'(grt_vec), 32'h0);

      // Lock holds ch2 for 6 cycles in total
      wgt_vec = 32'h1111_1111;
      req_vec = 8'h04;
      tick();
      chk("lock_g", 32'(grt_vec), 32'h04);
      lock = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("lock_hold", 32'(grt_vec), 32'h04);
      end
      lock    = 1'b0;
      req_vec = 8'h00;
      tick();
      chk("lock_end", 32'(grt_vec), 32'h0);

      // Mask and drop override lock
      req_vec = 8'h18;
      tick();
      chk("mask_g", 32'(grt_vec), 32'h08);
      lock = 1'b1;
      tick();
      chk("mask_hold", 32'(grt_vec), 32'h08);
      req_mask_vec = 8'h08;
      tick();
      chk("mask_move", 32'(grt_vec), 32'h10);
      chk("mask_idx", 32'(grt_idx), 32'h4);
      req_mask_vec = 8'h00;
      req_vec      = 8'h08;
      tick();
      chk("drop_move", 32'(grt_vec), 32'h08);
      req_vec = 8'h00;
      lock    = 1'b0;
      tick();
      chk("drop_idle", 32'(grt_vec), 32'h0);

      // Enable freeze mid-grant on ch5 (weight 3)
      wgt_vec = 32'h1131_1111;
      req_vec = 8'h60;
      tick();
      chk("frz_g", 32'(grt_vec), 32'h20);
      tick();
      chk("frz_g2", 32'(grt_vec), 32'h20);
      arbt_ena = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req_vec = (k % 2 == 0) ? 8'h41 : 8'h00;
         lock    = (k == 1);
         tick();
         chk("frz_vec", 32'(grt_vec), 32'h20);
         chk("frz_idx", 32'(grt_idx), 32'h5);
      end
      arbt_ena = 1'b1;
      lock     = 1'b0;
      req_vec  = 8'h60;
      tick();
      chk("frz_res1", 32'(grt_vec), 32'h20);
      tick();
      chk("frz_res2", 32'(grt_vec), 32'h40);
      tick();
      chk("frz_res3", 32'(grt_vec), 32'h20);

      // Asynchronous reset while granted, then restart from ptr=0
      rst = 1'b1;
      #1;
      chk("arst_vec", 32'(grt_vec), 32'h0);
      chk("arst_idx", 32'(grt_idx), 32'h0);
      chk("arst_vld", 32'(grt_vld), 32'h0);
      #1;
      rst     = 1'b0;
      req_vec = 8'h81;
      tick();
      chk("arst_restart", 32'(grt_vec), 32'h01);
      req_vec = 8'h00;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ns_gnrl_wrr_lock_arb.md
Name: ns_gnrl_wrr_lock_arb

Overview:
- Parametrised weighted round-robin arbiter; successor to the generic single-grant round-robin arbiters.
- Adds per-channel weights, i.e. consecutive grant credits, and a lock input that holds a grant across multi-beat transfers.
- Adds a request mask vector and registered one-hot, index and valid grant outputs.
- Sits in front of shared resources: the memory port, bus master mux and response path.

Parameters:
- ARBT_NUM, 8, number of requesting channels (>=2).
- WGT_W, 4, bit width of each channel weight.
- IDX_W, $clog2(ARBT_NUM), width of the grant index (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_vec  in  ARBT_NUM  per-channel request.
- req_mask_vec  in  ARBT_NUM  1 = channel excluded from arbitration.
- wgt_vec  in  ARBT_NUM*WGT_W  per-channel weight; channel i uses bits [i*WGT_W +: WGT_W].
- arbt_ena  in  1  arbitration enable; 0 freezes all state.
- lock  in  1  hold the current grant without consuming credit.
- grt_vec  out  ARBT_NUM  registered one-hot grant.
- grt_idx  out  IDX_W  registered binary index of the granted channel.
- grt_vld  out  1  registered; 1 when grt_vec is non-zero.

Behaviour:
- Reset (async, rst=1): grt_vec=0, grt_idx=0, grt_vld=0, ptr=0, credit=0, state=IDLE. Release is sampled on the first clk edge after rst deasserts.
- elig = req_vec & ~req_mask_vec.
- Effective weight: w_eff = (wgt==0) ? 1 : wgt.
- Pick function: first set bit of elig, searching circularly from ptr upward, wrapping ARBT_NUM-1 -> 0.
- arbt_ena=0: every register holds its value, including the outputs; lock and request changes are ignored that cycle.
- State IDLE (grt_vld=0):
  - On an enabled edge with elig != 0: grant pick(elig, ptr), load credit = w_eff-1, go to GRANT.
  - Latency: a request sampled at edge N shows a grant after edge N; no combinational req->grt path.
- State GRANT, on each enabled edge, with g = current grant:
  - elig[g]=0 (request dropped or channel masked): release, ignoring lock and credit.
  - Else lock=1: hold g; credit unchanged.
  - Else credit>0: hold g; credit decrements.
  - Else (credit==0): release.
- Release sets ptr = (g+1) mod ARBT_NUM and re-arbitrates in the same edge among elig, computed with ptr'. Channel g may win only if it is the sole eligible channel.
  - If a winner exists: new grant, credit = w_eff-1, stay in GRANT (back-to-back grants, no bubble).
  - If none: grt_vec=0, grt_vld=0, state IDLE.
  - grt_idx keeps its last value while grt_vld=0.
- Weight changes take effect only at the next credit load.
- Invariants: grt_vec is one-hot or zero; grt_vld == |grt_vec; a granted channel always had elig=1 at the granting edge.
- Reset asserted mid-grant: outputs clear immediately (asynchronously); the next grant starts from ptr=0.

Decomposition:
- Package ns_arb_pkg holds:
  - state enum arb_st_e {ARB_IDLE, ARB_GRANT};
  - a function for circular first-one-from-pointer on a one-hot/index;
  - the localparam default weight width.
- Sub-module ns_rr_pick: combinational circular priority picker.
  - Inputs: vec, ptr. Outputs: onehot, idx, found.
  - Implement as double-width masked find-first; reusable by the existing arbiters.

Test Plan:
- Reset: rst pulsed while grt_vld=1 with ARBT_NUM=8 -> grt_vec=0x00, grt_idx=0, grt_vld=0 immediately, before any clk edge.
- Fair alternation: all weights 1, arbt_ena=1, lock=0, req_vec=0x81 held -> grt_vec sequence 0x01, 0x80, 0x01, 0x80 with no idle cycles; this also exercises 7->0 wrap.
- Weighting: wgt ch0=3, ch1=1, others 0, req_vec=0x03 -> repeating 0x01, 0x01, 0x01, 0x02. Weight 0 on ch2 with req_vec=0x04 -> one grant per turn.
- Lock: req_vec=0x04, weight 1, lock=1 for 5 cycles after the grant -> grt_vec=0x04 for 6 cycles, then 0x00.
- Mask/drop: ch3 granted with lock=1, then req_mask_vec[3]=1 -> grant moves to the next eligible channel at the next edge; a request drop behaves the same.
- Enable freeze: arbt_ena=0 for 4 cycles mid-grant while req_vec changes -> grt_vec, grt_idx and credit unchanged; the sequence resumes exactly when arbt_ena returns to 1.
